sar_level_finder: RTL

//  Successive-approximation controller that is the driving side of the 8-bit magnitude comparator.
//  It drives a trial value onto the comparator P input, where Q is the unknown sensor level.
//  It reads back the less/equal/greater flags and converges on the sensor level one bit per clock.
//  The result is used by the health-monitor threshold logic; this block is the search side, the comparator only answers.

---
 rtl/sar_level_finder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sar_level_finder.sv
// Successive-approximation search controller: drives trial values into a magnitude
// comparator and converges on the unknown level one bit per clock.
module sar_level_finder #(
    parameter int WIDTH      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             cmpLess,
    input  logic             cmpEqual,
    input  logic             cmpGreater,
    output logic [WIDTH-1:0] probeValue,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             exact,
    output logic             error
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [BW-1:0]    TOP_BIT   = BW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] TOP_PROBE = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_TRIAL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_probe;
    logic [WIDTH-1:0] r_result;
    logic [BW-1:0]    r_bit;
    logic             r_exact;
    logic             r_error;

    logic             w_onehot;
    logic             w_hit;
    logic             w_last;
    logic             w_finish;
    logic [WIDTH-1:0] w_acc_new;
    logic [WIDTH-1:0] w_next_probe;

    // A greater answer drops the trial bit; less or equal keeps it.
    assign w_onehot     = $onehot({cmpLess, cmpEqual, cmpGreater});
    assign w_hit        = cmpEqual && EARLY_EXIT;
    assign w_last       = (r_bit == '0);
    assign w_finish     = !w_onehot || w_hit || w_last;
    assign w_acc_new    = cmpGreater ? r_acc : r_probe;
    assign w_next_probe = w_acc_new | ((WIDTH'(1) << r_bit) >> 1);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default assignment first, so no path through the case infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_TRIAL;
            S_TRIAL: if (w_finish) w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_TRIAL);
        done = (r_state == S_DONE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc    <= '0;
            r_probe  <= '0;
            r_result <= '0;
            r_bit    <= TOP_BIT;
            r_exact  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_acc   <= '0;
                        r_bit   <= TOP_BIT;
                        r_probe <= TOP_PROBE;
                        r_exact <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                S_TRIAL: begin
                    if (!w_onehot) begin
                        r_result <= '0;
                        r_exact  <= 1'b0;
                        r_error  <= 1'b1;
                    end else if (w_hit) begin
                        r_result <= r_probe;
                        r_exact  <= 1'b1;
                    end else begin
                        if (cmpEqual) r_exact <= 1'b1;
                        if (w_last) begin
                            r_result <= w_acc_new;
                        end else begin
                            r_acc   <= w_acc_new;
                            r_probe <= w_next_probe;
                            r_bit   <= r_bit - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign probeValue = r_probe;
    assign result     = r_result;
    assign exact      = r_exact;
    assign error      = r_error;

endmodule
